// File: rtl/mux_2x1_arbiter.sv
// Two-requester round-robin arbiter driving the select/invSelect pair of a
// shared 2:1 NAND mux. A grant is held across multi-cycle transactions. A hold
// counter forces a switch when one owner keeps the datapath too long while the
// other requester is waiting.
module mux_2x1_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] done,
   output logic [1:0] gnt,
   output logic       select,
   output logic       invSelect,
   output logic       busy,
   output logic       preempt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // A MAX_HOLD of zero turns forced switching off.
   localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST  = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [CNT_W-1:0] HOLD_MAX   = '1;

   state_t           state;
   logic             last;
   logic [CNT_W-1:0] hold_cnt;

   state_t           next_c;
   state_t           own_state_c;
   state_t           oth_state_c;
   logic [CNT_W-1:0] hold_next_c;
   logic             preempt_c;
   logic             owner_c;
   logic             other_c;
   logic             own_req_c;
   logic             oth_req_c;
   logic             own_done_c;
   logic             release_c;

   // Next-state arbitration, hold counting and preemption decision.
   always_comb begin
      next_c      = state;
      hold_next_c = '0;
      preempt_c   = 1'b0;

      owner_c     = (state == OWN1);
      other_c     = ~owner_c;
      own_req_c   = req[owner_c];
      oth_req_c   = req[other_c];
      own_done_c  = done[owner_c];
      release_c   = own_done_c | ~own_req_c;
      own_state_c = owner_c ? OWN1 : OWN0;
      oth_state_c = owner_c ? OWN0 : OWN1;

      case (state)
         IDLE: begin
            case (req)
               2'b01:   next_c = OWN0;
               2'b10:   next_c = OWN1;
               // Tie goes to whoever did not own the datapath last.
               2'b11:   next_c = last ? OWN0 : OWN1;
               default: next_c = IDLE;
            endcase
         end
         OWN0, OWN1: begin
            if (release_c) begin
               // Release resolves in the same edge: waiting peer first, then
               // a back-to-back re-grant, otherwise drop to idle.
               if (oth_req_c) begin
                  next_c = oth_state_c;
               end else if (own_req_c) begin
                  next_c = own_state_c;
               end else begin
                  next_c = IDLE;
               end
            end else if (oth_req_c) begin
               if (PREEMPT_EN && (hold_cnt == HOLD_LAST)) begin
                  next_c    = oth_state_c;
                  preempt_c = 1'b1;
               end else begin
                  hold_next_c = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
               end
            end
         end
         default: next_c = IDLE;
      endcase
   end

   // State, history and registered outputs decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         hold_cnt  <= '0;
         gnt       <= 2'b00;
         select    <= 1'b0;
         invSelect <= 1'b1;
         busy      <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         state    <= next_c;
         hold_cnt <= hold_next_c;
         preempt  <= preempt_c;
         gnt      <= {next_c == OWN1, next_c == OWN0};
         busy     <= (next_c != IDLE);
         // In idle the mux select is left alone so the datapath input is stable.
         if (next_c != IDLE) begin
            last      <= (next_c == OWN1);
            select    <= (next_c == OWN1);
            invSelect <= (next_c != OWN1);
         end
      end
   end

   // Structural invariants of the grant and select outputs.
   a_gnt_not_both : assert property (@(posedge clk) disable iff (reset) gnt != 2'b11);
   a_sel_compl    : assert property (@(posedge clk) disable iff (reset) invSelect == ~select);
   a_busy_match   : assert property (@(posedge clk) disable iff (reset) busy == |gnt);
   a_pre_onehot   : assert property (@(posedge clk) disable iff (reset)
                                     preempt |-> (gnt == 2'b01 || gnt == 2'b10));

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Self-checking bench for mux_2x1_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbitration rules.
module tb_mux_2x1_arbiter;

   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = 4;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] done;
   logic [1:0] gnt;
   logic       select;
   logic       invSelect;
   logic       busy;
   logic       preempt;

   int n_run;
   int n_fail;

   // Reference model: owner is -1 when idle, else requester index.
   int   m_owner;
   int   m_last;
   int   m_wait;
   logic m_sel;
   logic m_pre;

   mux_2x1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .select    (select),
      .invSelect (invSelect),
      .busy      (busy),
      .preempt   (preempt)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [5:0] obs();
      return {gnt, select, invSelect, busy, preempt};
   endfunction

   function automatic logic [5:0] exp_vec();
      logic [1:0] g;
      g = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
      return {g, m_sel, ~m_sel, (m_owner >= 0), m_pre};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1;
      m_wait  = 0;
      m_sel   = 1'b0;
      m_pre   = 1'b0;
   endtask

   // One clock of the arbitration rules, from sampled req/done.
   task automatic model_step(input logic [1:0] r, input logic [1:0] d);
      int o;
      int j;
      int nxt;
      o     = m_owner;
      m_pre = 1'b0;
      if (o < 0) begin
         if (r == 2'b01)      nxt = 0;
         else if (r == 2'b10) nxt = 1;
         else if (r == 2'b11) nxt = 1 - m_last;
         else                 nxt = -1;
         m_wait = 0;
      end else begin
         j = 1 - o;
         if (d[o] || !r[o]) begin
            nxt    = r[j] ? j : (r[o] ? o : -1);
            m_wait = 0;
         end else if (r[j]) begin
            if (MAX_HOLD > 0 && m_wait + 1 >= MAX_HOLD) begin
               nxt    = j;
               m_pre  = 1'b1;
               m_wait = 0;
            end else begin
               nxt    = o;
               m_wait = m_wait + 1;
            end
         end else begin
            nxt    = o;
            m_wait = 0;
         end
      end
      if (nxt >= 0) begin
         m_last = nxt;
         m_sel  = (nxt == 1);
      end
      m_owner = nxt;
   endtask

   // Drive one cycle of inputs, advance the model and check invariants.
   task automatic step(input logic [1:0] r, input logic [1:0] d);
      logic inv_ok;
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      @(negedge clk);
      inv_ok = (gnt !== 2'b11) && (invSelect === ~select) && (busy === |gnt) &&
               (!preempt || gnt === 2'b01 || gnt === 2'b10);
      n_run++;
      if (!inv_ok) begin
         n_fail++;
         $display("FAIL invariant t=%0t gnt=%b sel=%b inv=%b busy=%b pre=%b",
                  $time, gnt, select, invSelect, busy, preempt);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 2'bxx;
      done  = 2'bxx;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      req   = 2'b00;
      done  = 2'b00;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_run++;
      if (obs() !== 6'b00_0_1_0_0) begin
         n_fail++;
         $display("FAIL reset_values got=%b want=%b", obs(), 6'b00_0_1_0_0);
      end
   endtask

   // Single requester grant and release.
   task automatic test_single();
      do_reset();
      step(2'b01, 2'b00);
      n_run++;
      if (obs() !== 6'b01_0_1_1_0) begin
         n_fail++;
         $display("FAIL single_grant got=%b want=%b", obs(), 6'b01_0_1_1_0);
      end
      step(2'b00, 2'b01);
      n_run++;
      if (obs() !== 6'b00_0_1_0_0) begin
         n_fail++;
         $display("FAIL single_release got=%b want=%b", obs(), 6'b00_0_1_0_0);
      end
      step(2'b10, 2'b00);
      step(2'b00, 2'b00);
      n_run++;
      if (obs() !== 6'b00_1_0_0_0) begin
         n_fail++;
         $display("FAIL idle_select_hold got=%b want=%b", obs(), 6'b00_1_0_0_0);
      end
   endtask

   // Tie breaking and handover without an idle bubble.
   task automatic test_tie();
      do_reset();
      step(2'b11, 2'b00);
      n_run++;
      if (obs() !== 6'b01_0_1_1_0) begin
         n_fail++;
         $display("FAIL tie_first got=%b want=%b", obs(), 6'b01_0_1_1_0);
      end
      step(2'b11, 2'b01);
      n_run++;
      if (obs() !== 6'b10_1_0_1_0) begin
         n_fail++;
         $display("FAIL tie_handover got=%b want=%b", obs(), 6'b10_1_0_1_0);
      end
      step(2'b11, 2'b10);
      n_run++;
      if (obs() !== 6'b01_0_1_1_0) begin
         n_fail++;
         $display("FAIL tie_handback got=%b want=%b", obs(), 6'b01_0_1_1_0);
      end
      step(2'b00, 2'b00);
   endtask

   // Forced switch after MAX_HOLD waiting cycles.
   task automatic test_preempt();
      do_reset();
      step(2'b01, 2'b00);
      for (int k = 1; k <= MAX_HOLD; k++) begin
         step(2'b11, 2'b00);
         n_run++;
         if (k < MAX_HOLD) begin
            if (obs() !== 6'b01_0_1_1_0) begin
               n_fail++;
               $display("FAIL preempt_hold k=%0d got=%b want=%b", k, obs(), 6'b01_0_1_1_0);
            end
         end else if (obs() !== 6'b10_1_0_1_1) begin
            n_fail++;
            $display("FAIL preempt_switch got=%b want=%b", obs(), 6'b10_1_0_1_1);
         end
      end
      step(2'b11, 2'b00);
      n_run++;
      if (obs() !== 6'b10_1_0_1_0) begin
         n_fail++;
         $display("FAIL preempt_pulse_len got=%b want=%b", obs(), 6'b10_1_0_1_0);
      end
      step(2'b00, 2'b00);
      n_run++;
      if (obs() !== 6'b00_1_0_0_0) begin
         n_fail++;
         $display("FAIL preempt_drain got=%b want=%b", obs(), 6'b00_1_0_0_0);
      end
   endtask

   // Release coinciding with the preemption cycle.
   task automatic test_coincide();
      do_reset();
      step(2'b01, 2'b00);
      for (int k = 1; k < MAX_HOLD; k++) step(2'b11, 2'b00);
      step(2'b11, 2'b01);
      n_run++;
      if (obs() !== 6'b10_1_0_1_0) begin
         n_fail++;
         $display("FAIL coincide got=%b want=%b", obs(), 6'b10_1_0_1_0);
      end
      step(2'b00, 2'b00);
   endtask

   // Continuous back-to-back transactions by a single requester.
   task automatic test_back_to_back();
      int bad;
      do_reset();
      step(2'b01, 2'b00);
      bad = 0;
      for (int k = 1; k <= 24; k++) begin
         step(2'b01, (k % 3 == 0) ? 2'b01 : 2'b00);
         if (obs() !== 6'b01_0_1_1_0) bad++;
      end
      n_run++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL back_to_back bad_cycles=%0d want=0", bad);
      end
      step(2'b00, 2'b00);
   endtask

   // Reset asserted mid-transaction acts without a clock edge.
   task automatic test_reset_mid();
      do_reset();
      step(2'b10, 2'b00);
      n_run++;
      if (obs() !== 6'b10_1_0_1_0) begin
         n_fail++;
         $display("FAIL mid_own1 got=%b want=%b", obs(), 6'b10_1_0_1_0);
      end
      #2;
      reset = 1'b1;
      req   = 2'bxx;
      done  = 2'bxx;
      #1;
      n_run++;
      if (obs() !== 6'b00_0_1_0_0) begin
         n_fail++;
         $display("FAIL async_reset got=%b want=%b", obs(), 6'b00_0_1_0_0);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(2'b11, 2'b00);
      n_run++;
      if (obs() !== 6'b01_0_1_1_0) begin
         n_fail++;
         $display("FAIL after_reset_tie got=%b want=%b", obs(), 6'b01_0_1_1_0);
      end
      step(2'b00, 2'b00);
   endtask

   // Randomized traffic against the reference model.
   task automatic test_random();
      logic [1:0] r;
      logic [1:0] d;
      int         bad;
      do_reset();
      r   = 2'b00;
      bad = 0;
      for (int k = 0; k < 1500; k++) begin
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         end
         d[0] = ($urandom_range(0, 9) == 0);
         d[1] = ($urandom_range(0, 9) == 0);
         step(r, d);
         n_run++;
         if (obs() !== exp_vec()) begin
            n_fail++;
            bad++;
            if (bad <= 10)
               $display("FAIL random k=%0d req=%b done=%b got=%b want=%b",
                        k, r, d, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      reset  = 1'b1;
      req    = 2'b00;
      done   = 2'b00;
      model_reset();
      test_reset();
      test_single();
      test_tie();
      test_preempt();
      test_coincide();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
